mem_io_responder: RTL

Target end of the CPU byte-wide memory bus. It decodes each cycle's `mem_a`/`mem_wr` into a 128 KB RAM or a small I/O window at 0x30000. It returns read data one cycle later and accepts writes in one cycle. It also owns the UART-side FIFOs, the cycle counter, and the program-stop flag, and it generates the `io_buffer_full` backpressure signal the CPU consumes.

---
 rtl/mem_io_pkg.sv | 19 +
 rtl/byte_fifo.sv | 51 +++++
 rtl/mem_io_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared constants for the CPU memory/IO responder.
//   IO_SEL      : mem_a[17:16] value that selects the I/O window
//   IO_UART     : I/O offset of the UART data register
//   IO_CLK      : I/O offset of the cycle counter / program-stop register
//   *_DEPTH_DEF : default log2 FIFO depths
package mem_io_pkg;

    localparam logic [1:0] IO_SEL  = 2'b11;
    localparam logic [2:0] IO_UART = 3'd0;
    localparam logic [2:0] IO_CLK  = 3'd4;

    localparam int TX_DEPTH_DEF = 4;
    localparam int RX_DEPTH_DEF = 4;

    function automatic logic is_io(input logic [1:0] sel_bits);
        return sel_bits == IO_SEL;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: 8-bit synchronous FIFO, 2^DEPTH_LOG entries.
//   clk, rst_n : clock, synchronous active-low reset (discards contents)
//   push, din  : write request and data; a full FIFO still accepts a push
//                in a cycle where it also pops
//   pop, dout  : read request and head data (dout is combinational from head)
//   empty, full, count : occupancy status
module byte_fifo #(
    parameter int DEPTH_LOG = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               empty,
    output logic               full,
    output logic [DEPTH_LOG:0] count
);

    logic [7:0]         mem [0:(1<<DEPTH_LOG)-1];
    logic [DEPTH_LOG:0] wr_ptr;
    logic [DEPTH_LOG:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    // Extra pointer MSB: equal low bits with differing MSB means full.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG] != rd_ptr[DEPTH_LOG]) &&
                     (wr_ptr[DEPTH_LOG-1:0] == rd_ptr[DEPTH_LOG-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[DEPTH_LOG-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG-1:0]] <= din;
    end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: target of the CPU byte-wide memory bus.
//   clk_in, rst_in         : clock, synchronous active-low reset
//   mem_a/mem_wr/mem_wdata : per-cycle access (every non-write cycle is a read)
//   mem_rdata              : read byte, one cycle after the address
//   io_buffer_full         : registered tx near-full backpressure
//   rx_valid/rx_data/rx_ready : UART receive side into the rx FIFO
//   tx_valid/tx_data/tx_ready : UART transmit side from the tx FIFO
//   program_done, tx_overflow : sticky status flags
// RAM lives below the I/O window; I/O is selected by mem_a[17:16]==2'b11.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH_LOG   = TX_DEPTH_DEF,
    parameter int RX_DEPTH_LOG   = RX_DEPTH_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        io_buffer_full,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        program_done,
    output logic        tx_overflow
);

    // Two-entry margin absorbs writes already in flight when the CPU sees full.
    localparam logic [TX_DEPTH_LOG:0] TX_MARK = (TX_DEPTH_LOG+1)'((1 << TX_DEPTH_LOG) - 2);

    logic [7:0]  ram [0:(1<<RAM_ADDR_WIDTH)-1];
    logic [31:0] cycle_cnt;
    logic [31:0] snap;

    logic        io_sel;
    logic [2:0]  io_off;
    logic        io_wr;
    logic        rx_pop, rx_push, rx_empty, rx_full;
    logic [7:0]  rx_dout;
    logic [RX_DEPTH_LOG:0] rx_count;
    logic        tx_push_req, tx_pop, tx_empty, tx_full;
    logic [7:0]  tx_din;
    logic [TX_DEPTH_LOG:0] tx_count;
    logic        unused_bits;

    assign io_sel = is_io(mem_a[17:16]);
    assign io_off = mem_a[2:0];
    assign io_wr  = io_sel && mem_wr;

    assign rx_ready = !rx_full;
    assign rx_push  = rx_valid && rx_ready;
    assign rx_pop   = io_sel && !mem_wr && (io_off == IO_UART);

    // Offset 4 write emits a 0x00 terminator; nothing is pushed once stopped.
    assign tx_push_req = io_wr && !program_done &&
                         (((io_off == IO_UART) && (mem_wdata != 8'h00)) || (io_off == IO_CLK));
    assign tx_din   = (io_off == IO_CLK) ? 8'h00 : mem_wdata;
    assign tx_valid = !tx_empty;
    assign tx_pop   = tx_valid && tx_ready;

    assign unused_bits = ^{mem_a[31:18], rx_count};

    byte_fifo #(.DEPTH_LOG(RX_DEPTH_LOG)) u_rx_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_dout),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

    byte_fifo #(.DEPTH_LOG(TX_DEPTH_LOG)) u_tx_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .push  (tx_push_req),
        .pop   (tx_pop),
        .din   (tx_din),
        .dout  (tx_data),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

    always_ff @(posedge clk_in) begin
        if (mem_wr && !io_sel) ram[mem_a[RAM_ADDR_WIDTH-1:0]] <= mem_wdata;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            mem_rdata      <= 8'h00;
            io_buffer_full <= 1'b0;
            program_done   <= 1'b0;
            tx_overflow    <= 1'b0;
            cycle_cnt      <= '0;
            snap           <= '0;
        end else begin
            cycle_cnt      <= cycle_cnt + 1'b1;
            io_buffer_full <= (tx_count >= TX_MARK);
            if (io_wr && (io_off == IO_CLK)) program_done <= 1'b1;
            // A pop in the same cycle frees a slot, so only a stalled full FIFO drops.
            if (tx_push_req && tx_full && !tx_pop) tx_overflow <= 1'b1;
            // mem_rdata holds through write cycles.
            if (!mem_wr) begin
                if (!io_sel) begin
                    mem_rdata <= ram[mem_a[RAM_ADDR_WIDTH-1:0]];
                end else begin
                    case (io_off)
                        IO_UART: mem_rdata <= rx_empty ? 8'h00 : rx_dout;
                        IO_CLK: begin
                            mem_rdata <= cycle_cnt[7:0];
                            snap      <= cycle_cnt;
                        end
                        3'd5:    mem_rdata <= snap[15:8];
                        3'd6:    mem_rdata <= snap[23:16];
                        3'd7:    mem_rdata <= snap[31:24];
                        default: mem_rdata <= 8'h00;
                    endcase
                end
            end
        end
    end

endmodule
